// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD constants and helpers for the clock datapath counters.
package clock_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    function automatic logic [7:0] to_bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic bcd_legal(input logic [3:0] h, input logic [3:0] l, input int mn, input int mx);
        int v;
        v = 10 * int'(h) + int'(l);
        return h <= BCD_MAX_DIGIT && l <= BCD_MAX_DIGIT && v >= mn && v <= mx;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit stepped up or down, wrapping at 0/wrap with carry/borrow out.
module bcd_digit_step (
    input  logic [3:0] digit,
    input  logic       up,
    input  logic [3:0] wrap,
    output logic [3:0] step,
    output logic       carry
);
    always_comb begin
        carry = up ? digit == wrap : digit == 4'd0;
        step  = carry ? (up ? 4'd0 : wrap) : (up ? digit + 4'd1 : digit - 4'd1);
    end
endmodule

// File: rtl/bcd_range_counter.sv
// bcd_range_counter: two-digit BCD up/down counter over MIN_VAL..MAX_VAL with preset load,
// terminal count for cascading, and recovery from illegal states.
module bcd_range_counter
    import clock_pkg::*;
#(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 23
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_h,
    input  logic [3:0] load_l,
    output logic [3:0] cntH,
    output logic [3:0] cntL,
    output logic       tc
);
    localparam logic [7:0] MIN_BCD = to_bcd8(MIN_VAL);
    localparam logic [7:0] MAX_BCD = to_bcd8(MAX_VAL);

    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99) begin : g_bad_range
        $fatal(1, "bcd_range_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
    end

    logic       legal, load_ok, at_max, at_min, edge_wrap, carry_l, carry_h;
    logic [3:0] step_l, step_h;
    logic [7:0] nxt;

    assign legal   = bcd_legal(cntH, cntL, MIN_VAL, MAX_VAL);
    assign load_ok = bcd_legal(load_h, load_l, MIN_VAL, MAX_VAL);
    assign at_max  = {cntH, cntL} == MAX_BCD;
    assign at_min  = {cntH, cntL} == MIN_BCD;

    bcd_digit_step u_units (.digit(cntL), .up(up), .wrap(BCD_MAX_DIGIT), .step(step_l), .carry(carry_l));
    bcd_digit_step u_tens  (.digit(cntH), .up(up), .wrap(BCD_MAX_DIGIT), .step(step_h), .carry(carry_h));

    // A two-digit carry (99 up / 00 down) is always a range edge too, so it wraps the same way.
    always_comb begin
        edge_wrap = (up ? at_max : at_min) | (carry_l & carry_h);
        nxt = {cntH, cntL};
        if (load)
            nxt = load_ok ? {load_h, load_l} : MIN_BCD;
        else if (enable)
            nxt = !legal ? MIN_BCD : edge_wrap ? (up ? MIN_BCD : MAX_BCD) : {carry_l ? step_h : cntH, step_l};
    end

    assign tc = rstn & enable & ~load & legal & (up ? at_max : at_min);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            {cntH, cntL} <= MIN_BCD;
        else
            {cntH, cntL} <= nxt;
    end
endmodule
